fib_top_level: RTL and testbench

FIB_TOP_LEVEL -- requirements
Module: fib_top_level

---
 rtl/fib_top_level.sv | 184 ++++++++++++++++++
 tb/tb_fib_top_level.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fib_top_level.sv
// -----------------------------------------------------------------------------
// fib_top_level
//   Sequential evaluator for the recurrence
//     f(0) = 1, f(1) = 1, f(k) = (k-1)*f(k-1) + (k-2)*f(k-2)   for k >= 2
//   One recurrence step per clock. The index N is latched on the first edge
//   after reset release; the result is presented on `out` with `outReady`
//   high and held until the next reset.
//
//   Configuration macro:
//     FIB_SATURATE_EN  - when defined, each step is evaluated at full width and
//                        any step result above 1023 sets a sticky overflow bit;
//                        a computation that overflowed presents out = 1023.
//                        When undefined, all arithmetic wraps modulo 1024.
//
//   Reset is synchronous and active-high.
// -----------------------------------------------------------------------------
module fib_top_level (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] N,
    output logic [9:0] out,
    output logic       outReady
);

    // -------------------------------------------------------------------------
    // Controller states
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        LOAD = 2'd0,   // waiting to latch N after reset release
        CALC = 2'd1,   // one recurrence step per edge
        DONE = 2'd2    // result held on out
    } state_t;

    localparam logic [9:0] SAT_VALUE = 10'd1023;

    state_t     state;
    state_t     state_next;

    // A holds f(k-2), B holds f(k-1) at the start of each CALC step
    logic [9:0] a_q;
    logic [9:0] a_next;
    logic [9:0] b_q;
    logic [9:0] b_next;
    logic [4:0] k_q;
    logic [4:0] k_next;
    logic [4:0] n_q;
    logic [4:0] n_next;
    logic [9:0] out_q;
    logic [9:0] out_next;

    // Multiplier coefficients for the current step
    logic [4:0] coef_b;
    logic [4:0] coef_a;

    // Truncated result of the current step, and whether it exceeded 10 bits
    logic [9:0] step_val;
    logic       step_ovf;

`ifdef FIB_SATURATE_EN
    logic        ovf_q;
    logic        ovf_next;
    logic [14:0] prod_b;
    logic [14:0] prod_a;
    logic [15:0] step_full;
`endif

    // -------------------------------------------------------------------------
    // Recurrence step: combinational 5-bit x 10-bit multiplies
    // -------------------------------------------------------------------------
    always_comb begin
        coef_b = k_q - 5'd1;
        coef_a = k_q - 5'd2;
`ifdef FIB_SATURATE_EN
        // Full-width products so that any step exceeding 1023 is visible.
        prod_b    = {10'd0, coef_b} * {5'd0, b_q};
        prod_a    = {10'd0, coef_a} * {5'd0, a_q};
        step_full = {1'b0, prod_b} + {1'b0, prod_a};
        step_val  = step_full[9:0];
        step_ovf  = |step_full[15:10];
`else
        // Every product and the sum wrap modulo 1024.
        step_val  = ({5'd0, coef_b} * b_q) + ({5'd0, coef_a} * a_q);
        step_ovf  = 1'b0;
`endif
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath-next logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        a_next     = a_q;
        b_next     = b_q;
        k_next     = k_q;
        n_next     = n_q;
        out_next   = out_q;
`ifdef FIB_SATURATE_EN
        ovf_next   = ovf_q;
`endif

        case (state)
            LOAD: begin
                n_next = N;
                a_next = 10'd1;
                b_next = 10'd1;
                k_next = 5'd2;
`ifdef FIB_SATURATE_EN
                ovf_next = 1'b0;
`endif
                if (N < 5'd2) begin
                    out_next   = 10'd1;
                    state_next = DONE;
                end else begin
                    state_next = CALC;
                end
            end

            CALC: begin
                b_next = step_val;
                a_next = b_q;
`ifdef FIB_SATURATE_EN
                ovf_next = ovf_q | step_ovf;
`endif
                if (k_q == n_q) begin
`ifdef FIB_SATURATE_EN
                    out_next = (ovf_q | step_ovf) ? SAT_VALUE : step_val;
`else
                    out_next = step_val;
`endif
                    state_next = DONE;
                end else begin
                    k_next = k_q + 5'd1;
                end
            end

            DONE: begin
                // Hold everything until reset.
                state_next = DONE;
            end

            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers with synchronous reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every register sees
        // the pre-edge values of the others, independent of statement order.
        if (rst) begin
            state <= LOAD;
            a_q   <= 10'd1;
            b_q   <= 10'd1;
            k_q   <= 5'd2;
            n_q   <= 5'd0;
            out_q <= 10'd0;
`ifdef FIB_SATURATE_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            a_q   <= a_next;
            b_q   <= b_next;
            k_q   <= k_next;
            n_q   <= n_next;
            out_q <= out_next;
`ifdef FIB_SATURATE_EN
            ovf_q <= ovf_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: result register and ready flag decoded from the state register
    // -------------------------------------------------------------------------
    assign out      = out_q;
    assign outReady = (state == DONE);

endmodule

// File: tb/tb_fib_top_level.sv
// -----------------------------------------------------------------------------
// tb_fib_top_level
//   Scoreboard bench for fib_top_level. Stimulus pushes the expected result
//   and latency when it releases reset; an independent monitor pops and
//   compares when outReady rises, and checks out is held while in DONE.
//   Expected values come from a plain-arithmetic evaluation of the recurrence.
//   Define FIB_SATURATE_EN for both bench and RTL to exercise saturation.
// -----------------------------------------------------------------------------
module tb_fib_top_level;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] N   = 5'd0;
    logic [9:0] out;
    logic       outReady;

    always #5 clk = ~clk;

    fib_top_level dut (
        .clk      (clk),
        .rst      (rst),
        .N        (N),
        .out      (out),
        .outReady (outReady)
    );

    typedef struct {
        int value;
        int latency;
    } exp_t;

    exp_t sb[$];
    int   n_vectors     = 0;
    int   n_miscompares = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: evaluate the recurrence with integer arithmetic, 10-bit wrap.
    function automatic int ref_fib(input int n);
        int f[0:31];
        bit ovf;
        ovf  = 1'b0;
        f[0] = 1;
        f[1] = 1;
        for (int k = 2; k <= n; k++) begin
            int full;
            full = (k - 1) * f[k-1] + (k - 2) * f[k-2];
            if (full > 1023) ovf = 1'b1;
            f[k] = full % 1024;
        end
`ifdef FIB_SATURATE_EN
        if (ovf) return 1023;
`endif
        return f[n];
    endfunction

    function automatic int ref_latency(input int n);
        return (n < 2) ? 1 : n;
    endfunction

    // ---------------------------------------------------------------- monitor
    int edges      = 0;
    bit prev_ready = 1'b0;
    int held       = 0;

    always @(posedge clk) begin
        bit rst_s;
        rst_s = rst;
        if (rst_s) edges = 0;
        else       edges++;
        #1;
        if (rst_s) begin
            check("reset_out", int'(out), 0);
            check("reset_ready", int'(outReady), 0);
            prev_ready = 1'b0;
        end else if (outReady && !prev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", int'(outReady), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", int'(out), e.value);
                check("latency", edges, e.latency);
                held = e.value;
            end
            prev_ready = 1'b1;
        end else if (prev_ready) begin
            check("ready_held", int'(outReady), 1);
            check("out_held", int'(out), held);
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic pulse_reset(input logic [4:0] n_after);
        @(negedge clk);
        rst = 1'b1;
        N   = 5'($urandom);
        @(negedge clk);
        rst = 1'b0;
        N   = n_after;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && !outReady; i++) @(negedge clk);
        if (!outReady) check({name, "_timeout"}, int'(outReady), 1);
    endtask

    task automatic run_case(input int n);
        exp_t e;
        e.value   = ref_fib(n);
        e.latency = ref_latency(n);
        sb.push_back(e);
        pulse_reset(5'(n));
        wait_done($sformatf("n%0d", n));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);

        // Directed values, boundaries and the wrap/saturate point
        run_case(3);
        run_case(4);
        run_case(5);
        run_case(6);
        run_case(0);
        run_case(1);
        run_case(2);
        run_case(7);
        run_case(31);

        // Abort: N=6, reset asserted on edge 3, then N=5
        pulse_reset(5'd6);
        @(negedge clk);
        check("abort_ready_e1", int'(outReady), 0);
        @(negedge clk);
        check("abort_ready_e2", int'(outReady), 0);
        e.value   = ref_fib(5);
        e.latency = ref_latency(5);
        sb.push_back(e);
        rst = 1'b1;
        N   = 5'd5;
        @(negedge clk);
        rst = 1'b0;
        wait_done("abort_n5");
        repeat (3) @(negedge clk);

        // N changes after the load edge must be ignored
        e.value   = ref_fib(4);
        e.latency = ref_latency(4);
        sb.push_back(e);
        pulse_reset(5'd4);
        @(negedge clk);
        @(negedge clk);
        N = 5'd6;
        wait_done("nchange");
        repeat (3) @(negedge clk);

        // Randomized indices
        repeat (12) run_case(int'($urandom_range(0, 31)));

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog expired");
    end

endmodule
